// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default line timing and frame format.
// Used by both uart_tx and uart_rx.
package uart_pkg;

    localparam int DEFAULT_CLK_FREQ  = 50_000_000;
    localparam int DEFAULT_BAUD_RATE = 9600;
    localparam int DATA_BITS         = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last clock of each bit.
// pre_tick flags the clock before that, so a registered output can land on the last clock.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic bit_tick,
    output logic pre_tick
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    // With a one-clock bit every clock is a last clock, so pre_tick stays high.
    localparam logic [CW-1:0] PRE  = CW'((CLKS_PER_BIT > 1) ? CLKS_PER_BIT - 2 : 0);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || restart) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign bit_tick = (cnt == LAST);
    assign pre_tick = (cnt == PRE);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8 data bits, 1 or 2 stop bits, LSB first, idle-high line.
// A one-entry holding register in front of the shift register allows zero-gap frames.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = DEFAULT_CLK_FREQ,
    parameter int BAUD_RATE = DEFAULT_BAUD_RATE,
    parameter int STOP_BITS = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  data_in,
    input  logic        data_valid,
    output logic        ready,
    output logic        tx,
    output logic        busy,
    output logic        tx_done,
    output uart_state_t dbg_state
);
    localparam int         CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam logic [2:0] LAST_DATA    = 3'(DATA_BITS - 1);
    localparam logic [2:0] LAST_STOP    = 3'(STOP_BITS - 1);

    uart_state_t state_q, state_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic        tx_q, tx_d;
    logic        done_q, done_d;
    logic [7:0]  shift_q;
    logic [7:0]  hold_q;
    logic        hold_full;
    logic        load;
    logic        accept;
    logic        bit_tick;
    logic        pre_tick;

    // Handshake: a byte transfers on a posedge where data_valid && ready; ready is
    // ~hold_full straight from a flop, so it never depends on data_valid.
    assign ready  = ~hold_full;
    assign accept = data_valid & ready;

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (load),
        .bit_tick(bit_tick),
        .pre_tick(pre_tick)
    );

    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        tx_d      = tx_q;
        load      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (hold_full) begin
                    load    = 1'b1;
                    tx_d    = 1'b0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (bit_tick) begin
                    state_d   = ST_DATA;
                    bit_idx_d = '0;
                    tx_d      = shift_q[0];
                end
            end
            ST_DATA: begin
                if (bit_tick) begin
                    if (bit_idx_q == LAST_DATA) begin
                        state_d   = ST_STOP;
                        bit_idx_d = '0;
                        tx_d      = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shift_q[bit_idx_q + 3'd1];
                    end
                end
            end
            ST_STOP: begin
                if (bit_tick) begin
                    if (bit_idx_q == LAST_STOP) begin
                        bit_idx_d = '0;
                        if (hold_full) begin
                            load    = 1'b1;
                            tx_d    = 1'b0;
                            state_d = ST_START;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Registered pulse: set one clock early so it occupies the final stop clock.
        done_d = (state_d == ST_STOP) && (bit_idx_d == LAST_STOP) && pre_tick;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            bit_idx_q <= '0;
            tx_q      <= 1'b1;
            done_q    <= 1'b0;
            shift_q   <= '0;
            hold_q    <= '0;
            hold_full <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_idx_q <= bit_idx_d;
            tx_q      <= tx_d;
            done_q    <= done_d;
            if (load) begin
                shift_q   <= hold_q;
                hold_full <= 1'b0;
            end else if (accept) begin
                hold_q    <= data_in;
                hold_full <= 1'b1;
            end
        end
    end

    assign tx        = tx_q;
    assign tx_done   = done_q;
    assign busy      = (state_q != ST_IDLE) | hold_full;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: one instance with 1 stop bit, one with 2, line activity logged per clock
// and compared against an ideal frame waveform and a mid-bit sampling receiver model.
module tb_uart_tx;
    import uart_pkg::*;

    localparam int CLK_FREQ  = 1_000_000;
    localparam int BAUD_RATE = 100_000;
    localparam int N         = CLK_FREQ / BAUD_RATE;
    localparam int LOG_N     = 8192;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  data_in    [2];
    logic        data_valid [2];
    logic        ready      [2];
    logic        tx         [2];
    logic        busy       [2];
    logic        tx_done    [2];
    uart_state_t dbg_state  [2];

    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;
    logic [7:0] exp_q[$];

    logic log_tx   [2][LOG_N];
    logic log_done [2][LOG_N];
    logic log_rdy  [2][LOG_N];
    logic log_busy [2][LOG_N];

    uart_tx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .STOP_BITS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .data_in(data_in[0]), .data_valid(data_valid[0]),
        .ready(ready[0]), .tx(tx[0]), .busy(busy[0]), .tx_done(tx_done[0]),
        .dbg_state(dbg_state[0])
    );

    uart_tx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .STOP_BITS(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .data_in(data_in[1]), .data_valid(data_valid[1]),
        .ready(ready[1]), .tx(tx[1]), .busy(busy[1]), .tx_done(tx_done[1]),
        .dbg_state(dbg_state[1])
    );

    // ---------------- clock / reset / logging ----------------
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Entry e holds the outputs as they stand after posedge number e.
    always @(negedge clk) begin
        if (cyc < LOG_N) begin
            for (int s = 0; s < 2; s++) begin
                log_tx[s][cyc]   = tx[s];
                log_done[s][cyc] = tx_done[s];
                log_rdy[s][cyc]  = ready[s];
                log_busy[s][cyc] = busy[s];
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic logic exp_line(logic [7:0] b, int k);
        if (k < N)          return 1'b0;
        else if (k < 9 * N) return b[k / N - 1];
        else                return 1'b1;
    endfunction

    function automatic int frame_errs(int s, logic [7:0] b, int start, int stop_bits);
        int errs = 0;
        if (log_tx[s][start - 1] !== 1'b1) errs++;
        for (int k = 0; k < (9 + stop_bits) * N; k++)
            if (log_tx[s][start + k] !== exp_line(b, k)) errs++;
        return errs;
    endfunction

    function automatic int done_count(int s, int from, int to);
        int c = 0;
        for (int e = from; e <= to; e++)
            if (log_done[s][e] === 1'b1) c++;
        return c;
    endfunction

    function automatic int find_start(int s, int from, int to);
        for (int e = from; e <= to; e++)
            if (log_tx[s][e - 1] === 1'b1 && log_tx[s][e] === 1'b0) return e;
        return -1;
    endfunction

    function automatic logic [7:0] rx_decode(int s, int start);
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = log_tx[s][start + N * (i + 1) + N / 2];
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic send_byte(input int s, input logic [7:0] b, output int acc);
        int guard = 0;
        acc = -1;
        @(negedge clk);
        data_in[s]    = b;
        data_valid[s] = 1'b1;
        while (ready[s] !== 1'b1 && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        n_tests++;
        if (ready[s] !== 1'b1) begin
            n_fail++;
            $display("FAIL accept_timeout dut%0d: ready=%b required 1 within 1000 clks", s, ready[s]);
        end else begin
            @(posedge clk);
            #1;
            acc = cyc;
            exp_q.push_back(b);
        end
    endtask

    task automatic drop_valid(input int s);
        @(negedge clk);
        data_valid[s] = 1'b0;
    endtask

    task automatic wait_until(input int e);
        while (cyc < e) @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        for (int s = 0; s < 2; s++) begin
            data_in[s] = 8'h00;
            data_valid[s] = 1'b0;
        end
        @(posedge clk);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            for (int s = 0; s < 2; s++) begin
                n_tests++;
                if ({tx[s], ready[s], busy[s], tx_done[s]} !== 4'b1100 || dbg_state[s] !== ST_IDLE) begin
                    n_fail++;
                    $display("FAIL reset_hold dut%0d: tx/ready/busy/done=%b state=%0d required 1100 state 0",
                             s, {tx[s], ready[s], busy[s], tx_done[s]}, dbg_state[s]);
                end
            end
            if (c == 3) rst_n = 1'b1;
        end
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            n_tests++;
            if ({tx[s], ready[s], busy[s], tx_done[s]} !== 4'b1100) begin
                n_fail++;
                $display("FAIL reset_release dut%0d: tx/ready/busy/done=%b required 1100",
                         s, {tx[s], ready[s], busy[s], tx_done[s]});
            end
        end
    endtask

    task automatic test_single();
        int acc, st, errs, dc;
        logic [7:0] b, got, exp;
        for (int i = 0; i < 5; i++) begin
            b = (i == 0) ? 8'hA5 : 8'($urandom_range(0, 255));
            repeat ($urandom_range(0, 20)) @(negedge clk);
            send_byte(0, b, acc);
            drop_valid(0);
            if (acc >= 0) begin
                wait_until(acc + 1 + 10 * N + 4);
                st = find_start(0, acc, acc + 20);
                n_tests++;
                if (st !== acc + 1) begin
                    n_fail++;
                    $display("FAIL single_latency: start edge %0d required %0d", st, acc + 1);
                end
                errs = frame_errs(0, b, acc + 1, 1);
                n_tests++;
                if (errs !== 0) begin
                    n_fail++;
                    $display("FAIL single_wave byte %h: %0d wrong clocks required 0", b, errs);
                end
                dc = done_count(0, acc + 1, acc + 10 * N + 3);
                n_tests++;
                if (log_done[0][acc + 10 * N] !== 1'b1 || dc !== 1) begin
                    n_fail++;
                    $display("FAIL single_done: done at clk100=%b count=%0d required 1 and 1",
                             log_done[0][acc + 10 * N], dc);
                end
                n_tests++;
                if (log_busy[0][acc + 1 + 10 * N] !== 1'b0 || log_busy[0][acc + 10 * N] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL single_busy: busy last/after=%b%b required 10",
                             log_busy[0][acc + 10 * N], log_busy[0][acc + 1 + 10 * N]);
                end
                got = rx_decode(0, acc + 1);
                exp = exp_q.pop_front();
                n_tests++;
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL single_loopback: got %h required %h", got, exp);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int acc1, acc2, st1, st2, errs, rdy_errs;
        logic [7:0] b1, b2, got, exp;
        for (int i = 0; i < 3; i++) begin
            b1 = (i == 0) ? 8'h00 : 8'($urandom_range(0, 255));
            b2 = (i == 0) ? 8'hFF : 8'($urandom_range(0, 255));
            send_byte(0, b1, acc1);
            send_byte(0, b2, acc2);
            drop_valid(0);
            if (acc1 >= 0 && acc2 >= 0) begin
                st1 = acc1 + 1;
                st2 = st1 + 10 * N;
                wait_until(st2 + 10 * N + 4);
                n_tests++;
                if (acc2 !== acc1 + 2) begin
                    n_fail++;
                    $display("FAIL b2b_accept: second accept edge %0d required %0d", acc2, acc1 + 2);
                end
                rdy_errs = 0;
                for (int e = acc2; e < st2; e++) if (log_rdy[0][e] !== 1'b0) rdy_errs++;
                if (log_rdy[0][st2] !== 1'b1) rdy_errs++;
                n_tests++;
                if (rdy_errs !== 0) begin
                    n_fail++;
                    $display("FAIL b2b_ready: %0d wrong clocks required 0", rdy_errs);
                end
                errs = frame_errs(0, b1, st1, 1) + frame_errs(0, b2, st2, 1);
                n_tests++;
                if (errs !== 0) begin
                    n_fail++;
                    $display("FAIL b2b_wave %h/%h: %0d wrong clocks required 0", b1, b2, errs);
                end
                n_tests++;
                if (done_count(0, st1, st2 + 10 * N + 3) !== 2 || log_done[0][st1 + 10 * N - 1] !== 1'b1
                    || log_done[0][st2 + 10 * N - 1] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_done: count=%0d required 2 at ends of both frames",
                             done_count(0, st1, st2 + 10 * N + 3));
                end
                got = rx_decode(0, st1);
                exp = exp_q.pop_front();
                n_tests++;
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL b2b_loopback1: got %h required %h", got, exp);
                end
                got = rx_decode(0, st2);
                exp = exp_q.pop_front();
                n_tests++;
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL b2b_loopback2: got %h required %h", got, exp);
                end
            end
        end
    endtask

    task automatic test_two_stop();
        int acc, st, errs, dc;
        logic [7:0] b, got, exp;
        for (int i = 0; i < 3; i++) begin
            b = (i == 0) ? 8'h3C : 8'($urandom_range(0, 255));
            send_byte(1, b, acc);
            drop_valid(1);
            if (acc >= 0) begin
                st = acc + 1;
                wait_until(st + 11 * N + 4);
                errs = frame_errs(1, b, st, 2);
                n_tests++;
                if (errs !== 0) begin
                    n_fail++;
                    $display("FAIL stop2_wave byte %h: %0d wrong clocks required 0", b, errs);
                end
                dc = done_count(1, st, st + 11 * N + 3);
                n_tests++;
                if (dc !== 1 || log_done[1][st + 11 * N - 1] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL stop2_done: count=%0d at clk110=%b required 1 and 1",
                             dc, log_done[1][st + 11 * N - 1]);
                end
                n_tests++;
                if (log_busy[1][st + 11 * N - 1] !== 1'b1 || log_busy[1][st + 11 * N] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL stop2_length: busy clk110/111=%b%b required 10",
                             log_busy[1][st + 11 * N - 1], log_busy[1][st + 11 * N]);
                end
                got = rx_decode(1, st);
                exp = exp_q.pop_front();
                n_tests++;
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL stop2_loopback: got %h required %h", got, exp);
                end
            end
        end
    endtask

    task automatic test_reset_abort();
        int acc, st, r, errs;
        logic [7:0] got, exp;
        send_byte(0, 8'h81, acc);
        drop_valid(0);
        if (acc >= 0) begin
            st = acc + 1;
            wait_until(st + 4 * N + 4);
            @(negedge clk);
            rst_n = 1'b0;
            @(posedge clk);
            #1;
            r = cyc;
            void'(exp_q.pop_back());
            @(negedge clk);
            rst_n = 1'b1;
            n_tests++;
            if (log_tx[0][r - 1] !== 1'b0 || {tx[0], ready[0], busy[0]} !== 3'b110) begin
                n_fail++;
                $display("FAIL abort_reset: tx before=%b tx/ready/busy=%b required 0 and 110",
                         log_tx[0][r - 1], {tx[0], ready[0], busy[0]});
            end
            wait_until(r + 12 * N);
            errs = done_count(0, st, r + 12 * N - 2);
            for (int e = r; e < r + 12 * N - 1; e++) if (log_tx[0][e] !== 1'b1) errs++;
            n_tests++;
            if (errs !== 0) begin
                n_fail++;
                $display("FAIL abort_quiet: %0d done pulses or low clocks required 0", errs);
            end
            send_byte(0, 8'h5A, acc);
            drop_valid(0);
            if (acc >= 0) begin
                wait_until(acc + 1 + 10 * N + 4);
                errs = frame_errs(0, 8'h5A, acc + 1, 1);
                n_tests++;
                if (errs !== 0) begin
                    n_fail++;
                    $display("FAIL abort_next_wave: %0d wrong clocks required 0", errs);
                end
                got = rx_decode(0, acc + 1);
                exp = exp_q.pop_front();
                n_tests++;
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL abort_next_loopback: got %h required %h", got, exp);
                end
            end
        end
    endtask

    task automatic test_hold_ignore();
        int acc1, acc2, st1, st2, errs, rdy_errs;
        logic [7:0] b1, b2, got, exp;
        b1 = 8'($urandom_range(0, 255));
        b2 = 8'($urandom_range(0, 255));
        send_byte(0, b1, acc1);
        send_byte(0, b2, acc2);
        rdy_errs = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            data_in[0] = c[0] ? 8'h22 : 8'h11;
            data_valid[0] = 1'b1;
            if (ready[0] !== 1'b0) rdy_errs++;
        end
        drop_valid(0);
        n_tests++;
        if (rdy_errs !== 0) begin
            n_fail++;
            $display("FAIL hold_ready: %0d clocks with ready high required 0", rdy_errs);
        end
        if (acc1 >= 0 && acc2 >= 0) begin
            st1 = acc1 + 1;
            st2 = st1 + 10 * N;
            wait_until(st2 + 10 * N + 60);
            errs = frame_errs(0, b1, st1, 1) + frame_errs(0, b2, st2, 1);
            n_tests++;
            if (errs !== 0) begin
                n_fail++;
                $display("FAIL hold_wave %h/%h: %0d wrong clocks required 0", b1, b2, errs);
            end
            n_tests++;
            if (find_start(0, st2 + 10 * N, st2 + 10 * N + 55) !== -1) begin
                n_fail++;
                $display("FAIL hold_extra_frame: start at %0d required none",
                         find_start(0, st2 + 10 * N, st2 + 10 * N + 55));
            end
            for (int k = 0; k < 2; k++) begin
                got = rx_decode(0, k == 0 ? st1 : st2);
                exp = exp_q.pop_front();
                n_tests++;
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL hold_loopback%0d: got %h required %h", k, got, exp);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_two_stop();
        test_reset_abort();
        test_hold_ignore();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
